decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised, pipelined RV32I instruction decode stage; the successor to `instr_decode`. It sits between fetch and execute and accepts one instruction plus its PC per cycle over a valid/ready handshake. It reads `regs` through two combinational read ports, with a writeback bypass, and presents a registered decoded bundle to execute. Compared with `instr_decode` it adds:
- full RV32I class decode (`lui`/`auipc`, load, store, ALU-imm, ALU-reg)
- PC-relative `branch_dest`
- backpressure, flush and an illegal-instruction flag

## Interface
Parameters:
- `XLEN`, 32 — datapath width (32 or 64); immediates sign-extend to `XLEN`
- `NOP_ON_ILLEGAL`, 0 — 1: illegal instructions are dropped (no `out_valid`); 0: passed on with `is_illegal`=1

Ports:
- `clk`  in  1  — the single clock
- `reset`  in  1  — asynchronous, active-low
- `in_valid`  in  1  — fetch has an instruction
- `in_ready`  out  1  — stage accepts this cycle
- `in_instr`  in  32  — instruction word
- `in_pc`  in  XLEN  — instruction address
- `flush`  in  1  — discard held and incoming instruction
- `raddr1`, `raddr2`  out  5  — register read addresses (rs1, rs2)
- `rdata1`, `rdata2`  in  XLEN  — combinational read data from `regs`
- `wb_en`  in  1  — register write this cycle (bypass)
- `wb_addr`  in  5  — bypass write address
- `wb_data`  in  XLEN  — bypass write data
- `out_valid`  out  1  — decoded bundle valid
- `out_ready`  in  1  — execute accepts
- `is_lui`, `is_auipc`, `is_load`, `is_store`, `is_branch`, `is_jump`, `is_reg`, `is_alu`, `is_illegal`  out  1 each — class flags
- `operand_a`, `operand_b`  out  XLEN — execute operands
- `imm`  out  XLEN — sign-extended immediate
- `store_data`  out  XLEN — rs2 value
- `branch_dest`  out  XLEN — `pc` + `imm`
- `pc`  out  XLEN — instruction address
- `dest`  out  5 — rd
- `func3`  out  3
- `func7`  out  1 — instr[30]

## Operation
- Accept when `in_valid` && `in_ready`; `in_ready` = !`out_valid` || `out_ready`.
- `raddr1`/`raddr2` = instr[19:15]/[24:20] when `in_valid`, else 0. Forced to 0 while `reset` is low.
- Bypass: if `wb_en` && `wb_addr` == raddrN && raddrN != 0, the value used is `wb_data`, else `rdataN`. x0 always reads 0.
- Immediate formats I/S/B/U/J per opcode; `imm` = 0 for R-type.
- Operand mapping:
  - `lui`: a=0, b=imm
  - `auipc`: a=pc, b=imm
  - `jal`: `is_jump`; a=pc, b=imm
  - `jalr`: `is_jump`&`is_reg`; a=rs1, b=imm
  - branch: a=rs1, b=rs2
  - load: a=rs1, b=imm
  - store: a=rs1, b=imm, `store_data`=rs2
  - ALU-imm: `is_alu`; a=rs1, b=imm
  - ALU-reg: `is_alu`&`is_reg`; a=rs1, b=rs2
- `dest` = 0 for branch, store and illegal.
- Illegal: instr[1:0] != 2'b11, an unknown opcode, or an invalid func3 for branch/load/store. Result: `is_illegal`=1, all other class flags 0.
- Flush: takes priority over accept. On the next edge `out_valid`=0 and any instruction accepted in the flush cycle is discarded. `in_ready` is unaffected.

## Timing
- Reset (async assert, sync release): every registered output is 0, including `out_valid`. `in_ready` is 1 in the first cycle after release.
- Latency 1: an instruction accepted at edge N is presented after edge N; it holds stable while `out_valid` && !`out_ready`.
- Full throughput: back-to-back acceptance with `out_ready` held high.
- Stall: with `out_ready`=0 and `out_valid`=1, `in_ready`=0 and the bundle is frozen; the register operands captured at acceptance are retained.
- Reset mid-stall: the held bundle is lost and `out_valid`=0 immediately.
- `branch_dest` and `pc` arithmetic is modulo 2^XLEN (wrap-around, no flag).

## Structure
- Package `decode_pkg` holds:
  - opcode localparams (OP_LUI 0110111, OP_AUIPC 0010111, OP_JAL 1101111, OP_JALR 1100111, OP_BRANCH 1100011, OP_LOAD 0000011, OP_STORE 0100011, OP_IMM 0010011, OP_REG 0110011)
  - the immediate-format enum
  - the decoded-bundle struct
- Sub-module `imm_gen`: combinational, takes instr and format and returns the `XLEN` sign-extended immediate.

## Test plan
- Reset low two cycles with `in_valid`=1 → every output 0, `out_valid`=0; after release `in_ready`=1.
- `jal x3,+2000` at pc 0x100 → `is_jump`=1, `operand_a`=0x100, `imm`=2000, `branch_dest`=0x8D0, `dest`=3, all other flags 0.
- `jalr x2,2000(x31)`, x31=12345 in `regs`; repeat with `wb_en`, `wb_addr`=31, `wb_data`=777 in the same cycle → first run `operand_a`=12345, second run `operand_a`=777 (bypass); `operand_b`=2000.
- `beq x15,x14,+2000` at pc 0, x15=9876, x14=4567, `out_ready`=0 for 3 cycles → `in_ready`=0, bundle frozen (a=9876, b=4567, `branch_dest`=2000, `func3`=000); released on `out_ready`=1.
- Stream `lui x5,0x12345` then `auipc x6,1` at pc 0x40, `flush` asserted the cycle `auipc` is accepted → `lui` delivers b=0x12345000; `auipc` never asserts `out_valid`.
- Instruction 0x00000000 with `NOP_ON_ILLEGAL`=0 → `out_valid`=1, `is_illegal`=1, `dest`=0; with `NOP_ON_ILLEGAL`=1 → no `out_valid`.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcodes, immediate formats and decoded control bundle for the RV32I decode stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  typedef enum logic [1:0] {
    A_ZERO,
    A_PC,
    A_RS1
  } sel_a_t;

  typedef struct packed {
    logic       is_lui;
    logic       is_auipc;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_reg;
    logic       is_alu;
    logic       is_illegal;
    logic [4:0] dest;
    logic [2:0] func3;
    logic       func7;
  } decode_ctrl_t;

  // RV32I only defines a subset of func3 codes for the memory and branch classes.
  function automatic logic func3_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b1;
    if (op == OP_BRANCH)
      ok = (f3 != 3'b010) && (f3 != 3'b011);
    else if (op == OP_LOAD)
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
    else if (op == OP_STORE)
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return ok;
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate extraction; every format sign-extends from instr[31] to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_bits;

  assign unused_bits = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: valid/ready input, bypassed register reads, one registered output bundle.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit NOP_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      raddr1,
  output logic [4:0]      raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            is_lui,
  output logic            is_auipc,
  output logic            is_load,
  output logic            is_store,
  output logic            is_branch,
  output logic            is_jump,
  output logic            is_reg,
  output logic            is_alu,
  output logic            is_illegal,
  output logic [XLEN-1:0] operand_a,
  output logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] branch_dest,
  output logic [XLEN-1:0] pc,
  output logic [4:0]      dest,
  output logic [2:0]      func3,
  output logic            func7
);

  logic [6:0]      opcode;
  decode_ctrl_t    ctrl_next;
  imm_fmt_t        fmt;
  sel_a_t          sel_a;
  logic            sel_b_rs2;
  logic [XLEN-1:0] imm_next;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] a_next;
  logic [XLEN-1:0] b_next;
  logic            accept;

  logic            out_valid_reg;
  decode_ctrl_t    ctrl_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] imm_reg;
  logic [XLEN-1:0] store_data_reg;
  logic [XLEN-1:0] branch_dest_reg;
  logic [XLEN-1:0] pc_reg;

  assign opcode   = in_instr[6:0];
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  assign raddr1 = (reset && in_valid) ? in_instr[19:15] : 5'd0;
  assign raddr2 = (reset && in_valid) ? in_instr[24:20] : 5'd0;

  // x0 is hard-wired; a same-cycle writeback wins over the register file read.
  assign rs1_val = (raddr1 == 5'd0) ? '0 :
                   (wb_en && (wb_addr == raddr1)) ? wb_data : rdata1;
  assign rs2_val = (raddr2 == 5'd0) ? '0 :
                   (wb_en && (wb_addr == raddr2)) ? wb_data : rdata2;

  always_comb begin
    ctrl_next       = '0;
    ctrl_next.dest  = in_instr[11:7];
    ctrl_next.func3 = in_instr[14:12];
    ctrl_next.func7 = in_instr[30];
    fmt             = IMM_R;
    sel_a           = A_RS1;
    sel_b_rs2       = 1'b0;
    if (in_instr[1:0] != 2'b11 || !func3_legal(opcode, in_instr[14:12])) begin
      ctrl_next.is_illegal = 1'b1;
    end else begin
      case (opcode)
        OP_LUI: begin
          ctrl_next.is_lui = 1'b1;
          fmt              = IMM_U;
          sel_a            = A_ZERO;
        end
        OP_AUIPC: begin
          ctrl_next.is_auipc = 1'b1;
          fmt                = IMM_U;
          sel_a              = A_PC;
        end
        OP_JAL: begin
          ctrl_next.is_jump = 1'b1;
          fmt               = IMM_J;
          sel_a             = A_PC;
        end
        OP_JALR: begin
          ctrl_next.is_jump = 1'b1;
          ctrl_next.is_reg  = 1'b1;
          fmt               = IMM_I;
        end
        OP_BRANCH: begin
          ctrl_next.is_branch = 1'b1;
          fmt                 = IMM_B;
          sel_b_rs2           = 1'b1;
        end
        OP_LOAD: begin
          ctrl_next.is_load = 1'b1;
          fmt               = IMM_I;
        end
        OP_STORE: begin
          ctrl_next.is_store = 1'b1;
          fmt                = IMM_S;
        end
        OP_IMM: begin
          ctrl_next.is_alu = 1'b1;
          fmt              = IMM_I;
        end
        OP_REG: begin
          ctrl_next.is_alu = 1'b1;
          ctrl_next.is_reg = 1'b1;
          sel_b_rs2        = 1'b1;
        end
        default: ctrl_next.is_illegal = 1'b1;
      endcase
    end
    if (ctrl_next.is_branch || ctrl_next.is_store || ctrl_next.is_illegal)
      ctrl_next.dest = 5'd0;
  end

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .instr(in_instr),
    .fmt  (fmt),
    .imm  (imm_next)
  );

  always_comb begin
    case (sel_a)
      A_ZERO:  a_next = '0;
      A_PC:    a_next = in_pc;
      default: a_next = rs1_val;
    endcase
    b_next = sel_b_rs2 ? rs2_val : imm_next;
  end

  // Flush beats accept; a stalled bundle stays frozen because only accept loads it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg   <= 1'b0;
      ctrl_reg        <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      imm_reg         <= '0;
      store_data_reg  <= '0;
      branch_dest_reg <= '0;
      pc_reg          <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg   <= !(NOP_ON_ILLEGAL && ctrl_next.is_illegal);
      ctrl_reg        <= ctrl_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      imm_reg         <= imm_next;
      store_data_reg  <= rs2_val;
      branch_dest_reg <= in_pc + imm_next;
      pc_reg          <= in_pc;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign is_lui      = ctrl_reg.is_lui;
  assign is_auipc    = ctrl_reg.is_auipc;
  assign is_load     = ctrl_reg.is_load;
  assign is_store    = ctrl_reg.is_store;
  assign is_branch   = ctrl_reg.is_branch;
  assign is_jump     = ctrl_reg.is_jump;
  assign is_reg      = ctrl_reg.is_reg;
  assign is_alu      = ctrl_reg.is_alu;
  assign is_illegal  = ctrl_reg.is_illegal;
  assign dest        = ctrl_reg.dest;
  assign func3       = ctrl_reg.func3;
  assign func7       = ctrl_reg.func7;
  assign operand_a   = a_reg;
  assign operand_b   = b_reg;
  assign imm         = imm_reg;
  assign store_data  = store_data_reg;
  assign branch_dest = branch_dest_reg;
  assign pc          = pc_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised scoreboard bench for decode_stage with a second NOP_ON_ILLEGAL=1 instance.
module tb_decode_stage;
  import decode_pkg::*;

  localparam logic [8:0] F_LUI = 9'h100, F_AUIPC = 9'h080, F_LOAD = 9'h040, F_STORE = 9'h020;
  localparam logic [8:0] F_BRANCH = 9'h010, F_JUMP = 9'h008, F_REG = 9'h004, F_ALU = 9'h002;
  localparam logic [8:0] F_ILL = 9'h001;

  typedef struct {
    logic [31:0] ins;
    logic [8:0]  flags;
    logic [31:0] a, b, imm, sd, bd, pc;
    logic [4:0]  dest;
    logic [2:0]  f3;
    logic        f7;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, wb_data = '0;
  logic [4:0]  wb_addr = '0;
  logic        in_ready, out_valid;
  logic [4:0]  raddr1, raddr2, dest;
  logic [31:0] rdata1, rdata2, operand_a, operand_b, imm, store_data, branch_dest, pc;
  logic        is_lui, is_auipc, is_load, is_store, is_branch, is_jump, is_reg, is_alu, is_illegal;
  logic [2:0]  func3;
  logic        func7;
  logic [8:0]  dut_flags;

  logic        n_in_ready, n_out_valid;
  logic [4:0]  n_raddr1, n_raddr2, n_dest;
  logic [31:0] n_rdata1, n_rdata2, n_a, n_b, n_imm, n_sd, n_bd, n_pc;
  logic        n_lui, n_auipc, n_load, n_store, n_branch, n_jump, n_reg, n_alu, n_ill;
  logic [2:0]  n_func3;
  logic        n_func7;

  logic [31:0] regs [32];
  assign rdata1   = regs[raddr1];
  assign rdata2   = regs[raddr2];
  assign n_rdata1 = regs[n_raddr1];
  assign n_rdata2 = regs[n_raddr2];
  assign dut_flags = {is_lui, is_auipc, is_load, is_store, is_branch, is_jump, is_reg, is_alu, is_illegal};

  decode_stage #(.XLEN(32), .NOP_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1),
    .rdata2(rdata2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .is_lui(is_lui), .is_auipc(is_auipc),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .is_reg(is_reg), .is_alu(is_alu), .is_illegal(is_illegal), .operand_a(operand_a),
    .operand_b(operand_b), .imm(imm), .store_data(store_data), .branch_dest(branch_dest),
    .pc(pc), .dest(dest), .func3(func3), .func7(func7)
  );

  decode_stage #(.XLEN(32), .NOP_ON_ILLEGAL(1'b1)) dut_nop (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .raddr1(n_raddr1), .raddr2(n_raddr2), .rdata1(n_rdata1),
    .rdata2(n_rdata2), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(n_out_valid), .out_ready(1'b1), .is_lui(n_lui), .is_auipc(n_auipc),
    .is_load(n_load), .is_store(n_store), .is_branch(n_branch), .is_jump(n_jump),
    .is_reg(n_reg), .is_alu(n_alu), .is_illegal(n_ill), .operand_a(n_a),
    .operand_b(n_b), .imm(n_imm), .store_data(n_sd), .branch_dest(n_bd),
    .pc(n_pc), .dest(n_dest), .func3(n_func3), .func7(n_func7)
  );

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[$];
  bit   mutate = 1'b0;
  bit   last_acc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (wb_en && wb_addr == addr) return wb_data;
    return regs[addr];
  endfunction

  // Reference decode built from the ISA tables with integer arithmetic.
  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] pcv);
    exp_t e;
    int s, iv;
    logic [2:0] f3;
    logic [31:0] r1, r2;
    s  = ins;
    f3 = ins[14:12];
    r1 = src(ins[19:15]);
    r2 = src(ins[24:20]);
    iv = 0;
    e.ins = ins; e.pc = pcv; e.f3 = f3; e.f7 = ins[30]; e.dest = ins[11:7];
    e.a = r1; e.b = 32'd0; e.sd = r2; e.flags = F_ILL;
    case (ins[6:0])
      OP_LUI:   begin e.flags = F_LUI;   iv = ins & 32'hFFFFF000; e.a = 0; end
      OP_AUIPC: begin e.flags = F_AUIPC; iv = ins & 32'hFFFFF000; e.a = pcv; end
      OP_JAL: begin
        e.flags = F_JUMP; e.a = pcv;
        iv = ((s >>> 31) << 20) | (int'(ins[19:12]) << 12) | (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
      end
      OP_JALR:  begin e.flags = F_JUMP | F_REG; iv = s >>> 20; end
      OP_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
        e.flags = F_BRANCH;
        iv = ((s >>> 31) << 12) | (int'(ins[7]) << 11) | (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
      end
      OP_LOAD:  if (f3 != 3'd3 && f3 < 3'd6) begin e.flags = F_LOAD; iv = s >>> 20; end
      OP_STORE: if (f3 < 3'd3) begin e.flags = F_STORE; iv = ((s >>> 25) << 5) | int'(ins[11:7]); end
      OP_IMM:   begin e.flags = F_ALU; iv = s >>> 20; end
      OP_REG:   begin e.flags = F_ALU | F_REG; iv = 0; end
      default:  e.flags = F_ILL;
    endcase
    e.imm = iv;
    e.b   = (e.flags == F_BRANCH || e.flags == (F_ALU | F_REG)) ? r2 : e.imm;
    e.bd  = pcv + e.imm;
    if (e.flags == F_BRANCH || e.flags == F_STORE || e.flags == F_ILL) e.dest = 5'd0;
    return e;
  endfunction

  function automatic logic [31:0] enc_i(input int iv, input int rs1, input int rd, input logic [6:0] op);
    logic [31:0] v; logic [4:0] a, d;
    v = iv; a = rs1; d = rd;
    return {v[11:0], a, 3'b000, d, op};
  endfunction

  function automatic logic [31:0] enc_b(input int iv, input int rs2, input int rs1);
    logic [31:0] v; logic [4:0] a, b;
    v = iv; a = rs1; b = rs2;
    return {v[12], v[10:5], b, a, 3'b000, v[4:1], v[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input int iv, input int rd);
    logic [31:0] v; logic [4:0] d;
    v = iv; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d, OP_JAL};
  endfunction

  function automatic logic [31:0] enc_u(input int iv, input int rd, input logic [6:0] op);
    logic [31:0] v; logic [4:0] d;
    v = iv; d = rd;
    return {v[19:0], d, op};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] ops [9];
    int k;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    else if (k == 10) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pcv, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic ordy, input logic fl);
    in_valid = v; in_instr = ins; in_pc = pcv; wb_en = we; wb_addr = wa; wb_data = wd;
    out_ready = ordy; flush = fl;
    @(negedge clk);
    last_acc = v && in_ready;
    if (last_acc && !fl) q.push_back(predict(ins, pcv));
    @(posedge clk);
    #1;
    if (fl) q.delete();
    if (mutate) regs[$urandom_range(0, 31)] = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
  endtask

  // Scoreboard monitor: the front of the queue must be on the outputs whenever out_valid is high.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        check("valid_vs_pending", out_valid, q.size() != 0);
        if (out_valid && q.size() != 0) begin
          e = q[0];
          check("flags", dut_flags, e.flags);
          check("dest", dest, e.dest);
          check("func3", func3, e.f3);
          check("func7", func7, e.f7);
          check("pc", pc, e.pc);
          if (e.flags != F_ILL) begin
            check("operand_a", operand_a, e.a);
            check("operand_b", operand_b, e.b);
            check("imm", imm, e.imm);
            check("store_data", store_data, e.sd);
            check("branch_dest", branch_dest, e.bd);
          end
          if (out_ready) begin
            $display("txn instr=%h pc=%h flags=%b dest=%0d a=%h b=%h", e.ins, e.pc, e.flags, e.dest, e.a, e.b);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  // NOP_ON_ILLEGAL=1 instance always has out_ready high, so it should show valid exactly for legal accepts.
  initial begin
    exp_t e;
    logic nexp;
    nexp = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("nop_out_valid", n_out_valid, nexp);
        e = predict(in_instr, in_pc);
        nexp = in_valid && !flush && (e.flags != F_ILL);
      end else begin
        nexp = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] ins, pcv;
    logic v, held;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0]  = 32'hDEADBEEF;
    regs[31] = 32'd12345;
    regs[15] = 32'd9876;
    regs[14] = 32'd4567;

    reset = 1'b0; in_valid = 1'b1; in_instr = enc_j(2000, 3); in_pc = 32'h100; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", dut_flags, 0);
    check("rst_operand_a", operand_a, 0);
    check("rst_operand_b", operand_b, 0);
    check("rst_imm", imm, 0);
    check("rst_store_data", store_data, 0);
    check("rst_branch_dest", branch_dest, 0);
    check("rst_pc", pc, 0);
    check("rst_dest_func", {dest, func3, func7}, 0);
    check("rst_raddr", {raddr1, raddr2}, 0);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    check("ready_after_reset", in_ready, 1);
    @(posedge clk);
    #1;

    cycle(1'b1, enc_j(2000, 3), 32'h100, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("jal_flags", dut_flags, F_JUMP);
    check("jal_a", operand_a, 32'h100);
    check("jal_imm", imm, 32'd2000);
    check("jal_bdest", branch_dest, 32'h8D0);
    check("jal_dest", dest, 3);

    cycle(1'b1, enc_i(2000, 31, 2, OP_JALR), 32'h200, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("jalr_a_regs", operand_a, 32'd12345);
    check("jalr_b", operand_b, 32'd2000);
    cycle(1'b1, enc_i(2000, 31, 2, OP_JALR), 32'h204, 1'b1, 5'd31, 32'd777, 1'b1, 1'b0);
    check("jalr_a_bypass", operand_a, 32'd777);
    idle(2);

    cycle(1'b1, enc_b(2000, 14, 15), 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    regs[15] = 32'd1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, enc_u(1, 7, OP_LUI), 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
      check("stall_in_ready", in_ready, 0);
      check("stall_a", operand_a, 32'd9876);
      check("stall_b", operand_b, 32'd4567);
      check("stall_bdest", branch_dest, 32'd2000);
      check("stall_func3", func3, 0);
    end
    regs[15] = 32'd9876;
    cycle(1'b1, enc_u(1, 7, OP_LUI), 32'h10, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle(2);

    cycle(1'b1, enc_u(32'h12345, 5, OP_LUI), 32'h3C, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("lui_b", operand_b, 32'h12345000);
    check("nop_legal_valid", n_out_valid, 1);
    cycle(1'b1, enc_u(1, 6, OP_AUIPC), 32'h40, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1);
    check("auipc_flushed", out_valid, 0);
    idle(1);
    check("auipc_stays_gone", out_valid, 0);

    cycle(1'b1, 32'd0, 32'h80, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    check("ill_valid", out_valid, 1);
    check("ill_flag", dut_flags, F_ILL);
    check("ill_dest", dest, 0);
    check("nop_ill_valid", n_out_valid, 0);
    idle(2);

    mutate = 1'b1;
    held = 1'b0;
    ins = 32'd0;
    pcv = 32'd0;
    for (int k = 0; k < 700; k++) begin
      if (!held) begin
        ins = rand_instr();
        pcv = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : $urandom;
      end
      v = ($urandom_range(0, 4) != 0);
      cycle(v, ins, pcv, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 1) != 0) ? ins[19:15] : 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      held = v && !last_acc;
    end
    idle(3);
    check("drain_empty", q.size(), 0);

    mutate = 1'b0;
    cycle(1'b1, enc_i(5, 1, 4, OP_IMM), 32'h300, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    check("pre_reset_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    q.delete();
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    idle(2);
    check("post_reset_ready", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
